fwd_unit_multi: RTL

// Parametrised operand-forwarding unit for the pipeline's decode/EX boundary. It keeps a DEPTH-entry

---
 rtl/fwd_unit_multi.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fwd_unit_multi.sv
// Operand-forwarding unit: a shift-register history of in-flight destination writes, searched
// youngest-first (same-cycle push, then entries 0..DEPTH-1) for every source operand.
module fwd_unit_multi #(
  parameter int DATA_W   = 16,
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [NUM_SRC*REG_W-1:0]  src_num,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] rf_value,
  input  logic                      push_valid,
  input  logic [REG_W-1:0]          push_num,
  input  logic [DATA_W-1:0]         push_value,
  input  logic                      push_is_load,
  input  logic                      ld_fill_valid,
  input  logic [DATA_W-1:0]         ld_fill_value,
  output logic [NUM_SRC*DATA_W-1:0] op_value,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic                      stall,
  output logic                      pend_ovf
);

  logic [DEPTH-1:0]  ent_valid_reg;
  logic [DEPTH-1:0]  ent_pend_reg;
  logic [REG_W-1:0]  ent_num_reg   [DEPTH];
  logic [DATA_W-1:0] ent_value_reg [DEPTH];

  logic [DEPTH-1:0]  ent_valid_next;
  logic [DEPTH-1:0]  ent_pend_next;
  logic [REG_W-1:0]  ent_num_next   [DEPTH];
  logic [DATA_W-1:0] ent_value_next [DEPTH];

  logic                      new_load;
  logic                      pend_live;
  logic [NUM_SRC-1:0]        lk_hit;
  logic [NUM_SRC-1:0]        lk_haz;
  logic [NUM_SRC*DATA_W-1:0] lk_value;

  assign new_load = push_valid && push_is_load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lookup
      logic [REG_W-1:0]  s;
      logic              found;
      logic              pend;
      logic [DATA_W-1:0] val;
      logic              active;

      assign s = src_num[gi*REG_W +: REG_W];
      assign active = src_valid[gi] && !((ZERO_REG != 0) && (s == '0));

      always_comb begin
        found = 1'b0;
        pend  = 1'b0;
        val   = '0;
        if (push_valid && push_num == s) begin
          found = 1'b1;
          pend  = push_is_load;
          val   = push_value;
        end
        for (int j = 0; j < DEPTH; j++) begin
          if (!found && ent_valid_reg[j] && ent_num_reg[j] == s) begin
            found = 1'b1;
            pend  = ent_pend_reg[j];
            val   = ent_value_reg[j];
          end
        end
      end

      // A pending winner is only usable when its load data arrives this very cycle.
      assign lk_hit[gi] = active && found && (!pend || ld_fill_valid);
      assign lk_haz[gi] = active && found && pend && !ld_fill_valid;
      assign lk_value[gi*DATA_W +: DATA_W] = !lk_hit[gi] ? rf_value[gi*DATA_W +: DATA_W] :
                                             (pend ? ld_fill_value : val);
    end
  endgenerate

  always_comb begin
    pend_live = 1'b0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (ent_pend_reg[j] && !ld_fill_valid) pend_live = 1'b1;
    end
    ent_valid_next[0] = push_valid;
    ent_num_next[0]   = push_num;
    ent_value_next[0] = push_value;
    ent_pend_next[0]  = new_load;
    // A new load steals the pending role; the displaced entry keeps its stale value.
    for (int j = 1; j < DEPTH; j++) begin
      ent_valid_next[j] = ent_valid_reg[j-1];
      ent_num_next[j]   = ent_num_reg[j-1];
      ent_value_next[j] = (ent_pend_reg[j-1] && ld_fill_valid) ? ld_fill_value : ent_value_reg[j-1];
      ent_pend_next[j]  = ent_pend_reg[j-1] && !ld_fill_valid && !new_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_reg <= '0;
      ent_pend_reg  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        ent_num_reg[j]   <= '0;
        ent_value_reg[j] <= '0;
      end
      op_value <= '0;
      fwd_hit  <= '0;
      stall    <= 1'b0;
      pend_ovf <= 1'b0;
    end else if (enable) begin
      if (flush) begin
        ent_valid_reg <= '0;
        ent_pend_reg  <= '0;
        op_value      <= '0;
        fwd_hit       <= '0;
        stall         <= 1'b0;
        pend_ovf      <= 1'b0;
      end else begin
        ent_valid_reg <= ent_valid_next;
        ent_pend_reg  <= ent_pend_next;
        for (int j = 0; j < DEPTH; j++) begin
          ent_num_reg[j]   <= ent_num_next[j];
          ent_value_reg[j] <= ent_value_next[j];
        end
        stall <= |lk_haz;
        if (!(|lk_haz)) begin
          op_value <= lk_value;
          fwd_hit  <= lk_hit;
        end
        if (new_load && pend_live) pend_ovf <= 1'b1;
      end
    end
  end

endmodule
